wb_bus_arbiter: RTL and testbench

Round-robin Wishbone B4 classic-cycle arbiter for the badge's shared 16-bit-address/8-bit-data bus. It sits between the three bus masters (protocol/UART bridge, synth sequencer, LED matrix frame fetcher) and the slave fabric (frame memory, SID, LED matrix registers). It replaces the ad-hoc fixed-priority mux and cross-wired `cyc_i` blocking with registered, lock-until-release grants. It adds a bus-timeout watchdog so a missing slave ack cannot hang the bus.

---
 rtl/wb_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - Round-robin Wishbone B4 classic arbiter with bus-timeout watchdog
//
// Purpose: shares one Wishbone slave fabric between N_MASTERS masters. Grants are
// registered and held until the owner drops cyc; the next owner is chosen round-robin
// starting after the previous owner. A watchdog forces an error to the owner when a
// strobe goes unacked for TIMEOUT cycles.
//
// Ports:
//   clk_i, rst_ni        bus clock, asynchronous active-low reset
//   m_cyc_i .. m_cti_i   per-master request side (packed, master i at [i*W +: W])
//   m_gnt_o              one-hot registered grant
//   m_ack_o, m_err_o     per-master ack / timeout error (combinational)
//   m_dat_o              read data broadcast to all masters
//   s_*_o                slave-side signals muxed from the owner, 0 when idle
//   s_dat_i, s_ack_i     slave read data and ack
//   timeout_cnt_o        saturating count of watchdog firings since reset
module wb_bus_arbiter #(
  parameter int N_MASTERS     = 3,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_MASTERS-1:0]            m_cyc_i,
  input  logic [N_MASTERS-1:0]            m_stb_i,
  input  logic [N_MASTERS-1:0]            m_we_i,
  input  logic [N_MASTERS-1:0]            m_sel_i,
  input  logic [N_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [N_MASTERS*3-1:0]          m_cti_i,
  output logic [N_MASTERS-1:0]            m_gnt_o,
  output logic [N_MASTERS-1:0]            m_ack_o,
  output logic [N_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]           m_dat_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic                            s_sel_o,
  output logic [ADDRESS_WIDTH-1:0]        s_adr_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  output logic [2:0]                      s_cti_o,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  input  logic                            s_ack_i,
  output logic [7:0]                      timeout_cnt_o
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic [IW-1:0] LAST_RESET = IW'(N_MASTERS - 1);
  localparam logic [15:0]   WD_LIMIT   = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  // owner_q doubles as "last owner": it keeps its value through IDLE so the
  // rotation resumes after the most recent owner.
  logic [IW-1:0]          owner_q, owner_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [15:0]            wd_q, wd_d;
  logic [7:0]             tcnt_q;
  logic [IW-1:0]          rr_idx;
  logic                   strobing;
  logic                   fire;

  logic [N_MASTERS*ADDRESS_WIDTH-1:0] adr_sh;
  logic [N_MASTERS*DATA_WIDTH-1:0]    dat_sh;
  logic [N_MASTERS*3-1:0]             cti_sh;

  // First requester strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic logic [IW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                            input logic [IW-1:0] last);
    logic [IW-1:0]        pick;
    logic                 found;
    logic [N_MASTERS-1:0] req_sh;
    int                   cand;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand   = (int'(last) + k) % N_MASTERS;
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        pick  = IW'(cand);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_idx  = rr_pick(m_cyc_i, owner_q);
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = OWNED;
          owner_d = rr_idx;
        end
      end
      OWNED: begin
        // The departing owner has cyc low, so it can only be picked again
        // once it re-requests; handover happens on the same edge.
        if (!m_cyc_i[owner_q]) begin
          if (|m_cyc_i) owner_d = rr_idx;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == OWNED) ? (N_MASTERS'(1) << owner_d) : '0;
  end

  always_comb begin
    adr_sh  = m_adr_i >> (int'(owner_q) * ADDRESS_WIDTH);
    dat_sh  = m_dat_i >> (int'(owner_q) * DATA_WIDTH);
    cti_sh  = m_cti_i >> (int'(owner_q) * 3);
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    if (state_q == OWNED) begin
      s_cyc_o = m_cyc_i[owner_q];
      s_stb_o = m_stb_i[owner_q];
      s_we_o  = m_we_i[owner_q];
      s_sel_o = m_sel_i[owner_q];
      s_adr_o = adr_sh[ADDRESS_WIDTH-1:0];
      s_dat_o = dat_sh[DATA_WIDTH-1:0];
      s_cti_o = cti_sh[2:0];
    end
  end

  assign strobing = s_cyc_o & s_stb_o;
  // An ack in the would-be firing cycle wins: fire requires no ack.
  assign fire     = strobing & ~s_ack_i & (wd_q == WD_LIMIT);

  assign m_gnt_o       = gnt_q;
  assign m_err_o       = gnt_q & {N_MASTERS{fire}};
  assign m_ack_o       = {N_MASTERS{s_ack_i}} & gnt_q & m_stb_i & ~m_err_o;
  assign m_dat_o       = s_dat_i;
  assign timeout_cnt_o = tcnt_q;

  always_comb begin
    if ((gnt_d != gnt_q) || s_ack_i || fire) wd_d = '0;
    else if (strobing)                       wd_d = wd_q + 16'd1;
    else                                     wd_d = wd_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= LAST_RESET;
      gnt_q   <= '0;
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
      if (fire && (tcnt_q != 8'hFF)) tcnt_q <= tcnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - Scoreboard bench for wb_bus_arbiter
module tb_wb_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0, m_sel = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat = '0;
  logic [N*3-1:0]  m_cti = '0;
  logic [DW-1:0]   s_dat = '0;
  logic            s_ack = 1'b0;

  logic [N-1:0]    n_cyc = '0, n_stb = '0, n_we = '0, n_sel = '0;
  logic [N*AW-1:0] n_adr = '0;
  logic [N*DW-1:0] n_dat = '0;
  logic [N*3-1:0]  n_cti = '0;
  logic [DW-1:0]   n_sdat = '0;
  logic            n_ack = 1'b0;

  logic [N-1:0]  gnt, ack, err;
  logic [DW-1:0] mdat_o, sdat_o;
  logic          scyc, sstb, swe, ssel;
  logic [AW-1:0] sadr;
  logic [2:0]    scti;
  logic [7:0]    tcnt;

  wb_bus_arbiter #(.N_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cti_i(m_cti),
    .m_gnt_o(gnt), .m_ack_o(ack), .m_err_o(err), .m_dat_o(mdat_o),
    .s_cyc_o(scyc), .s_stb_o(sstb), .s_we_o(swe), .s_sel_o(ssel),
    .s_adr_o(sadr), .s_dat_o(sdat_o), .s_cti_o(scti),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .timeout_cnt_o(tcnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt, ack, err;
    logic          cyc, stb, we, sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat, mdat;
    logic [2:0]    cti;
    logic [7:0]    tcnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: owner index (-1 = nobody), last owner, watchdog count, event count.
  int owner_m = -1;
  int last_m  = N - 1;
  int wd_m    = 0;
  int tcnt_m  = 0;
  bit fire_m  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit has(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic apply();
    m_cyc = n_cyc; m_stb = n_stb; m_we = n_we; m_sel = n_sel;
    m_adr = n_adr; m_dat = n_dat; m_cti = n_cti;
    s_dat = n_sdat; s_ack = n_ack;
  endtask

  task automatic model_reset();
    owner_m = -1; last_m = N - 1; wd_m = 0; tcnt_m = 0; fire_m = 1'b0;
  endtask

  // Clock edge: uses the inputs of the cycle that just ended.
  task automatic model_edge();
    int old;
    int nxt;
    bit strobed;
    old = owner_m;
    strobed = (old >= 0) && has(m_cyc, old) && has(m_stb, old);
    if (owner_m < 0 || !has(m_cyc, owner_m)) begin
      nxt = -1;
      for (int k = 1; k <= N; k++) begin
        if (nxt < 0 && has(m_cyc, (last_m + k) % N)) nxt = (last_m + k) % N;
      end
      owner_m = nxt;
      if (nxt >= 0) last_m = nxt;
    end
    if (fire_m && tcnt_m < 255) tcnt_m++;
    if (owner_m != old)        wd_m = 0;
    else if (s_ack || fire_m)  wd_m = 0;
    else if (strobed)          wd_m++;
  endtask

  task automatic model_push();
    exp_t e;
    logic [N*AW-1:0] ta;
    logic [N*DW-1:0] td;
    logic [N*3-1:0]  tc;
    e = '0;
    if (owner_m >= 0) begin
      e.gnt = 3'(1) << owner_m;
      e.cyc = has(m_cyc, owner_m);
      e.stb = has(m_stb, owner_m);
      e.we  = has(m_we, owner_m);
      e.sel = has(m_sel, owner_m);
      ta = m_adr >> (owner_m * AW); e.adr = ta[AW-1:0];
      td = m_dat >> (owner_m * DW); e.dat = td[DW-1:0];
      tc = m_cti >> (owner_m * 3);  e.cti = tc[2:0];
    end
    fire_m = e.cyc && e.stb && !s_ack && (wd_m == TO - 1);
    e.ack  = (s_ack && owner_m >= 0 && has(m_stb, owner_m)) ? e.gnt : '0;
    e.err  = fire_m ? e.gnt : '0;
    e.mdat = s_dat;
    e.tcnt = 8'(tcnt_m);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    apply();
    model_push();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    n_sdat = 8'($urandom());
    s_dat  = n_sdat;
    rst_n  = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_scyc", 32'(scyc), 32'(0));
    chk("rst_sstb", 32'(sstb), 32'(0));
    chk("rst_sadr", 32'({swe, ssel, sadr, sdat_o, scti}), 32'(0));
    chk("rst_tcnt", 32'(tcnt), 32'(0));
    chk("rst_mdat", 32'(mdat_o), 32'(n_sdat));
    n_cyc = '0; n_stb = '0; n_we = '0; n_sel = '0; n_adr = '0; n_dat = '0;
    n_cti = '0; n_ack = 1'b0;
    apply();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_gnt", 32'(gnt), 32'(e.gnt));
      chk("sb_ack", 32'(ack), 32'(e.ack));
      chk("sb_err", 32'(err), 32'(e.err));
      chk("sb_scyc", 32'(scyc), 32'(e.cyc));
      chk("sb_sstb", 32'(sstb), 32'(e.stb));
      chk("sb_swe", 32'(swe), 32'(e.we));
      chk("sb_ssel", 32'(ssel), 32'(e.sel));
      chk("sb_sadr", 32'(sadr), 32'(e.adr));
      chk("sb_sdat", 32'(sdat_o), 32'(e.dat));
      chk("sb_scti", 32'(scti), 32'(e.cti));
      chk("sb_mdat", 32'(mdat_o), 32'(e.mdat));
      chk("sb_tcnt", 32'(tcnt), 32'(e.tcnt));
    end
  end

  initial begin
    #10000000;
    $display("FAIL bench_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single request from master 1.
    n_cyc = 3'b010; n_stb = 3'b010; n_we = 3'b010;
    n_adr = 48'h0000_1234_0000; n_dat = 24'h00_5A_00;
    step();
    step();
    @(negedge clk);
    chk("single_gnt", 32'(gnt), 32'(3'b010));
    chk("single_adr", 32'(sadr), 32'(16'h1234));
    chk("single_dat", 32'(sdat_o), 32'(8'h5A));
    chk("single_noack", 32'(ack), 32'(0));
    n_ack = 1'b1;
    step();
    @(negedge clk);
    chk("single_ack", 32'(ack), 32'(3'b010));
    n_ack = 1'b0;
    step();
    @(negedge clk);
    chk("single_ack_once", 32'(ack), 32'(0));
    n_cyc = '0; n_stb = '0;
    step();
    do_reset();

    // All three request; each drops cyc the cycle after its acked cycle.
    n_cyc = 3'b111; n_stb = 3'b111; n_ack = 1'b1;
    step();
    for (int t = 1; t <= 12; t++) begin
      n_cyc = (t % 2 == 0) ? (3'b111 & ~(3'(1) << ((t / 2 - 1) % 3))) : 3'b111;
      n_stb = n_cyc;
      step();
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), 32'(3'(1) << (((t - 1) / 2) % 3)));
    end
    do_reset();

    // Master 2 holds an 8-beat burst while 0 and 1 wait.
    n_cyc = 3'b100; n_stb = 3'b100; n_ack = 1'b1;
    n_cti = 9'b010_000_000;
    step();
    for (int b = 1; b <= 8; b++) begin
      n_cyc = 3'b111; n_stb = 3'b111;
      n_cti = (b == 8) ? 9'b111_000_000 : 9'b010_000_000;
      step();
      @(negedge clk);
      chk("burst_gnt", 32'(gnt), 32'(3'b100));
      chk("burst_cti", 32'(scti), (b == 8) ? 32'(3'b111) : 32'(3'b010));
    end
    n_cyc = 3'b011; n_stb = 3'b011;
    step();
    @(negedge clk);
    chk("burst_drop_gnt", 32'(gnt), 32'(3'b100));
    step();
    @(negedge clk);
    chk("burst_next0", 32'(gnt), 32'(3'b001));
    n_cyc = 3'b010; n_stb = 3'b010;
    step();
    @(negedge clk);
    chk("burst_drop0", 32'(gnt), 32'(3'b001));
    step();
    @(negedge clk);
    chk("burst_next1", 32'(gnt), 32'(3'b010));
    do_reset();

    // Watchdog: unacked strobes, then an ack exactly in the would-be firing cycle.
    n_cyc = 3'b010; n_stb = 3'b010; n_ack = 1'b0;
    step();
    for (int t = 1; t <= 13; t++) begin
      n_ack = (t == 12);
      step();
      @(negedge clk);
      chk("wd_err", 32'(err), (t == 4 || t == 8) ? 32'(3'b010) : 32'(0));
      chk("wd_ack", 32'(ack), (t == 12) ? 32'(3'b010) : 32'(0));
      chk("wd_tcnt", 32'(tcnt), (t <= 4) ? 32'(0) : (t <= 8) ? 32'(1) : 32'(2));
    end
    do_reset();

    // Reset mid-burst, then masters 1 and 2 request: master 1 wins.
    n_cyc = 3'b100; n_stb = 3'b100; n_cti = 9'b010_000_000; n_ack = 1'b1;
    step();
    step();
    step();
    do_reset();
    n_cyc = 3'b110; n_stb = 3'b110;
    step();
    step();
    @(negedge clk);
    chk("post_rst_gnt", 32'(gnt), 32'(3'b010));

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (n_cyc[i]) n_cyc[i] = ($urandom_range(0, 3) != 0);
        else          n_cyc[i] = ($urandom_range(0, 2) == 0);
        n_stb[i] = n_cyc[i] & ($urandom_range(0, 3) != 0);
      end
      n_we   = 3'($urandom());
      n_sel  = 3'($urandom());
      n_adr  = 48'({$urandom(), $urandom()});
      n_dat  = 24'($urandom());
      n_cti  = 9'($urandom());
      n_sdat = 8'($urandom());
      n_ack  = ($urandom_range(0, 3) == 0);
      step();
    end

    // Long stall drives the timeout counter into saturation.
    n_cyc = 3'b001; n_stb = 3'b001; n_ack = 1'b0;
    for (int c = 0; c < 1100; c++) step();
    @(negedge clk);
    chk("tcnt_sat", 32'(tcnt), 32'(255));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
